// File: rtl/ram_port_arb.sv
// Shares one external SRAM port between N_REQ requesters.
// Port 0 always wins; the rest are served round-robin. Each access is a fixed-length SRAM cycle.
module ram_port_arb #(
    parameter int N_REQ   = 4,
    parameter int ACC_CYC = 4,
    parameter int AW      = 23
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*8-1:0]  req_dati,
    output logic [N_REQ-1:0]    ack,
    output logic [7:0]          dato,
    output logic [2:0]          gnt_id,
    output logic                busy,
    output logic [AW-1:0]       ram_addr,
    output logic [7:0]          ram_dati,
    input  logic [7:0]          ram_dato,
    output logic                ram_ce,
    output logic                ram_oe,
    output logic                ram_we
);

    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [7:0]     dati_q;
    logic [2:0]     gnt_q;
    logic [2:0]     rr_q;
    logic [N_REQ-1:0] ack_q;
    logic [7:0]     dato_q;
    logic           ce_q;
    logic           oe_q;
    logic           wen_q;
    logic           busy_q;

    logic [7:0]     reqPad;
    logic [7:0]     wePad;
    logic [2:0]     winner_d;
    logic           found;
    int             cand;
    int             nextCnt;

    assign reqPad  = 8'(req);
    assign wePad   = 8'(req_we);
    assign nextCnt = int'(cnt_q) + 1;

    // Port 0 pre-empts; otherwise search ports 1..N_REQ-1 starting just after the last winner.
    always_comb begin
        winner_d = 3'd0;
        found    = 1'b0;
        cand     = 0;
        if (req[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i < N_REQ; i++) begin
                cand = ((int'(rr_q) - 1 + i) % (N_REQ - 1)) + 1;
                if (!found && reqPad[3'(cand)]) begin
                    winner_d = 3'(cand);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dati_q  <= '0;
            gnt_q   <= '0;
            rr_q    <= 3'(N_REQ - 1);
            ack_q   <= '0;
            dato_q  <= 8'hFF;
            ce_q    <= 1'b0;
            oe_q    <= 1'b0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        addr_q  <= req_addr[int'(winner_d)*AW +: AW];
                        dati_q  <= req_dati[int'(winner_d)*8 +: 8];
                        we_q    <= wePad[winner_d];
                        gnt_q   <= winner_d;
                        if (winner_d != 3'd0) begin
                            rr_q <= winner_d;
                        end
                        cnt_q   <= '0;
                        ce_q    <= 1'b1;
                        oe_q    <= !wePad[winner_d];
                        wen_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (cnt_q == CW'(ACC_CYC - 1)) begin
                        if (!we_q) begin
                            dato_q <= ram_dato;
                        end
                        ce_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        wen_q   <= 1'b0;
                        ack_q   <= N_REQ'(1) << gnt_q;
                        state_q <= DONE;
                    end else begin
                        // Strobe is computed for the next count so the registered output lines up with cnt.
                        cnt_q <= CW'(nextCnt);
                        wen_q <= we_q && (nextCnt >= 1) && (nextCnt <= ACC_CYC - 2);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign dato     = dato_q;
    assign gnt_id   = gnt_q;
    assign busy     = busy_q;
    assign ram_addr = addr_q;
    assign ram_dati = dati_q;
    assign ram_ce   = ce_q;
    assign ram_oe   = oe_q;
    assign ram_we   = wen_q;

endmodule

// File: tb/tb_ram_port_arb.sv
// Self-checking bench for ram_port_arb: table of single accesses, then arbitration and reset corner cases.
// Completed accesses are matched against a queue of expected ack/dato pairs.
module tb_ram_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [91:0] req_addr;
    logic [31:0] req_dati;
    logic [3:0]  ack;
    logic [7:0]  dato;
    logic [2:0]  gnt_id;
    logic        busy;
    logic [22:0] ram_addr;
    logic [7:0]  ram_dati;
    logic [7:0]  ram_dato;
    logic        ram_ce;
    logic        ram_oe;
    logic        ram_we;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] dato;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          port;
        bit          we;
        logic [22:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [7:0]  expDato;
    } vec_t;
    vec_t vecs[5];

    ram_port_arb #(.N_REQ(4), .ACC_CYC(4), .AW(23)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_dati(req_dati), .ack(ack), .dato(dato), .gnt_id(gnt_id), .busy(busy),
        .ram_addr(ram_addr), .ram_dati(ram_dati), .ram_dato(ram_dato), .ram_ce(ram_ce),
        .ram_oe(ram_oe), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops one expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                checkOutput("ack_onehot", 32'($onehot(ack)), 32'd1);
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb_ack", 32'(ack), 32'(e.ack));
                    checkOutput("sb_dato", 32'(dato), 32'(e.dato));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitAck(output logic [3:0] got);
        got = 4'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                got = ack;
                return;
            end
        end
        checkOutput("ack_timeout", 32'(got), 32'hF);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated access with cycle-by-cycle checks of the SRAM strobes and ack latency.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req[v.port]            = 1'b1;
        req_we[v.port]         = v.we;
        req_addr[v.port*23 +: 23] = v.addr;
        req_dati[v.port*8 +: 8]   = v.wd;
        ram_dato               = v.rd;
        sbq.push_back('{ack: 4'(1 << v.port), dato: v.expDato});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_addr[v.port*23 +: 23] = ~v.addr;
                req_dati[v.port*8 +: 8]   = ~v.wd;
            end
            checkOutput("acc_ce", 32'(ram_ce), 32'd1);
            checkOutput("acc_addr", 32'(ram_addr), 32'(v.addr));
            checkOutput("acc_oe", 32'(ram_oe), 32'(!v.we));
            checkOutput("acc_we", 32'(ram_we), 32'(v.we && c >= 1 && c <= 2));
            checkOutput("acc_gnt", 32'(gnt_id), 32'(v.port));
            checkOutput("acc_busy", 32'(busy), 32'd1);
            checkOutput("acc_no_ack", 32'(ack), 32'd0);
            if (v.we) checkOutput("acc_dati", 32'(ram_dati), 32'(v.wd));
        end
        @(negedge clk);
        checkOutput("ack_latency", 32'(ack), 32'(1 << v.port));
        checkOutput("done_strobes", 32'({ram_ce, ram_oe, ram_we}), 32'd0);
        req[v.port] = 1'b0;
        req_addr    = '0;
        req_dati    = '0;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] got;
        logic [3:0] ackAcc;
        int order[6] = '{1, 2, 3, 1, 2, 3};

        vecs[0] = '{port: 2, we: 1'b0, addr: 23'h012345, wd: 8'h00, rd: 8'hA5, expDato: 8'hA5};
        vecs[1] = '{port: 1, we: 1'b1, addr: 23'h400010, wd: 8'h3C, rd: 8'h00, expDato: 8'hA5};
        vecs[2] = '{port: 0, we: 1'b0, addr: 23'h000001, wd: 8'h00, rd: 8'h5A, expDato: 8'h5A};
        vecs[3] = '{port: 3, we: 1'b1, addr: 23'h7FFFFF, wd: 8'hFF, rd: 8'h12, expDato: 8'h5A};
        vecs[4] = '{port: 3, we: 1'b0, addr: 23'h000000, wd: 8'h00, rd: 8'h00, expDato: 8'h00};

        rst_n    = 1'b0;
        req      = 4'hF;
        req_we   = 4'h0;
        req_addr = '0;
        req_dati = '0;
        ram_dato = 8'h00;
        repeat (5) @(negedge clk);
        checkOutput("rst_strobes", 32'({ram_ce, ram_oe, ram_we}), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_dato", 32'(dato), 32'hFF);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_gnt", 32'(gnt_id), 32'd0);
        req   = 4'h0;
        rst_n = 1'b1;

        $display("[TB] table of single accesses");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] round-robin over ports 1..3, then port 0 pre-empts");
        @(negedge clk);
        req_we   = 4'h0;
        ram_dato = 8'h77;
        for (int i = 0; i < 6; i++) sbq.push_back('{ack: 4'(1 << order[i]), dato: 8'h77});
        req = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            waitAck(got);
            checkOutput("rr_order", 32'(got), 32'(1 << order[i]));
            checkOutput("rr_gnt", 32'(gnt_id), 32'(order[i]));
        end
        sbq.push_back('{ack: 4'b0001, dato: 8'h77});
        req = 4'b1111;
        waitAck(got);
        checkOutput("p0_preempt", 32'(got), 32'h1);
        req = 4'b0;
        repeat (2) @(negedge clk);

        $display("[TB] simultaneous port 0 and port 3 from reset");
        applyReset();
        @(negedge clk);
        ram_dato = 8'h11;
        sbq.push_back('{ack: 4'b0001, dato: 8'h11});
        sbq.push_back('{ack: 4'b1000, dato: 8'h11});
        req = 4'b1001;
        waitAck(got);
        checkOutput("simul_first", 32'(got), 32'h1);
        req[0] = 1'b0;
        waitAck(got);
        checkOutput("simul_second", 32'(got), 32'h8);
        req = 4'b0;
        @(negedge clk);
        // rr pointer now 3, so ports 1 and 2 together must start with 1.
        sbq.push_back('{ack: 4'b0010, dato: 8'h11});
        req = 4'b0110;
        waitAck(got);
        checkOutput("rr_after_3", 32'(got), 32'h2);
        req = 4'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset in the middle of a write");
        req[2]          = 1'b1;
        req_we[2]       = 1'b1;
        req_addr[46 +: 23] = 23'h000055;
        req_dati[16 +: 8]  = 8'h99;
        repeat (3) @(negedge clk);
        checkOutput("abort_we_pre", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        req   = 4'b0;
        @(negedge clk);
        checkOutput("abort_strobes", 32'({ram_ce, ram_oe, ram_we}), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        rst_n  = 1'b1;
        ackAcc = 4'b0;
        repeat (8) begin
            @(negedge clk);
            ackAcc = ackAcc | ack;
        end
        checkOutput("abort_no_ack", 32'(ackAcc), 32'd0);
        checkOutput("abort_dato", 32'(dato), 32'hFF);
        req_we   = 4'b0;
        req_addr = '0;
        req_dati = '0;
        applyStimulus('{port: 1, we: 1'b0, addr: 23'h0000AA, wd: 8'h00, rd: 8'hC3, expDato: 8'hC3});

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
